commutation_fsm: RTL and testbench
==================================

# commutation_fsm

Parametrised four-step commutation controller for the bidirectional-switch load matrix. Drives N_LOADS bidirectional switch pairs (2*N_LOADS gate bits) and moves conduction from the active load to a newly requested one using current-sign-based four-step commutation. Per-step dwell is programmable. A Short fault forces every gate off and latches until the operator clears it. It is the generalised successor of the fixed 3-load switch FSM and sits between the load-select/control logic and the gate drivers.

## Interface
- N_LOADS, default 3: number of bidirectional switch pairs; legal range is 2..2^SEL_W.
- SEL_W, default 2: width of DesiredLoad and active_load.
- STEP_CYCLES, default 4: cycles each of commutation steps 1–3 is held; must be ≥1.
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  reset, asynchronous assert, active-low.
- start  in  1  enable. 1 = energise or keep the selected load. 0 = de-energise once any commutation in progress completes.
- DesiredLoad  in  SEL_W  requested load index, 0..N_LOADS-1. Values ≥N_LOADS are invalid and ignored.
- CurrentSign  in  1  load current polarity: 1 = positive (forward device conducts), 0 = negative.
- Short  in  1  short-circuit detect, level-sensitive.
- Sout  out  2*N_LOADS  gate drive. Sout[2k] is the forward device of load k; Sout[2k+1] is the reverse device of load k.
- busy  out  1  high while in STEP1..STEP3.
- done  out  1  one-cycle pulse when a load becomes fully conducting.
- fault  out  1  high while in FAULT.
- active_load  out  SEL_W  index of the conducting, or outgoing, load.

## Operation
- All outputs are registered.
- Reset values: Sout=0, busy=0, done=0, fault=0, active_load=0, state=IDLE.
- States: IDLE, CONDUCT, STEP1, STEP2, STEP3, FAULT.
- Notation: A = the outgoing load (active_load). B = the latched target. c = the conducting device, chosen by the latched sign s: fwd if s=1, rev if s=0.
- IDLE: Sout=0.
  - start=1 with a valid DesiredLoad → CONDUCT: active_load=DesiredLoad, both devices of that load on, done pulses.
  - Invalid DesiredLoad, or start=0 → stay in IDLE.
- CONDUCT: both devices of A are on.
  - start=0 → IDLE, Sout=0.
  - Otherwise, a valid DesiredLoad≠A → latch B=DesiredLoad and s=CurrentSign, then go to STEP1.
  - DesiredLoad==A or invalid → hold.
- STEP1: only A.c is on (A's non-conducting device turned off).
- STEP2: A.c and B.c are on.
- STEP3: only B.c is on.
- After STEP3 → CONDUCT with both devices of B on; active_load=B; done pulses.
- If start=0 was seen at any point during STEP1..STEP3, go to IDLE instead of CONDUCT after STEP3 (Sout=0, no done pulse).
- During commutation, DesiredLoad and CurrentSign are ignored. They are re-evaluated only in CONDUCT.
- A commutation is never aborted, except by Short.
- Short=1 in any state → FAULT on the next edge: Sout=0, fault=1, busy=0, step counter cleared. Short has priority over every other transition.
- FAULT: Sout=0. Leave to IDLE only when Short=0 and start=0 in the same cycle. active_load holds its value.
- Step counter width is $clog2(STEP_CYCLES+1). It reloads on entry to each step.

## Timing
- IDLE start, sampled at edge t: Sout shows the target load's pair and done=1 from t+1.
- Commutation request sampled at edge t in CONDUCT (S = STEP_CYCLES):
  - STEP1 pattern from t+1 to t+S.
  - STEP2 pattern from t+S+1 to t+2S.
  - STEP3 pattern from t+2S+1 to t+3S.
  - CONDUCT(B) from t+3S+1, with done=1 for that one cycle.
- busy=1 exactly from t+1 to t+3S.
- Short sampled at edge t: Sout=0 and fault=1 from t+1.
- rst low: all outputs take their reset values immediately, asynchronously, including mid-commutation.
- Invariant: no more than two gate bits are ever high, and never both devices of two different loads at once.

## Test plan
- Reset, then start=0 for 10 cycles → Sout=000000, busy=0, done=0, fault=0 throughout.
- start=1, DesiredLoad=0 → next cycle Sout=000011, done pulses once, active_load=0.
- From load 0 with CurrentSign=1, DesiredLoad=2 → Sout=000001 for 4 cycles, then 010001 ×4, then 010000 ×4, then 110000. done pulses on the 110000 cycle, active_load=2, busy=1 for exactly 12 cycles.
- From load 2 with CurrentSign=0, DesiredLoad=1 → 100000 ×4, then 101000 ×4, then 001000 ×4, then 001100. Toggling CurrentSign mid-sequence changes nothing.
- Short=1 during STEP2 → next cycle Sout=000000, fault=1. Releasing Short with start=1 keeps FAULT; then start=0 → IDLE; then start=1 with DesiredLoad=1 → 001100.
- In CONDUCT: DesiredLoad=3 (invalid) → Sout unchanged, busy=0. Dropping start during STEP1 → the full sequence completes, then Sout=000000 with no done pulse. Asserting rst low mid-STEP2 → Sout=000000 immediately.

Source files
------------

// File: rtl/commutation_fsm.sv
// Four-step, current-sign-based commutation controller for an N_LOADS bidirectional switch matrix.
// Moves conduction between loads without ever shorting two full pairs; Short forces all gates off and latches.
module commutation_fsm #(
    parameter int N_LOADS     = 3,
    parameter int SEL_W       = 2,
    parameter int STEP_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [SEL_W-1:0]     DesiredLoad,
    input  logic                 CurrentSign,
    input  logic                 Short,
    output logic [2*N_LOADS-1:0] Sout,
    output logic                 busy,
    output logic                 done,
    output logic                 fault,
    output logic [SEL_W-1:0]     active_load
);

    localparam int CNT_W = $clog2(STEP_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(STEP_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CONDUCT = 3'd1,
        STEP1   = 3'd2,
        STEP2   = 3'd3,
        STEP3   = 3'd4,
        FAULT   = 3'd5
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [SEL_W-1:0]     tgt_q, tgt_d;
    logic                 sign_q, sign_d;
    logic                 stop_q, stop_d;
    logic [SEL_W-1:0]     act_q, act_d;
    logic [2*N_LOADS-1:0] sout_q, sout_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 fault_q, fault_d;

    logic desired_valid;
    assign desired_valid = ({1'b0, DesiredLoad} < (SEL_W+1)'(N_LOADS));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            tgt_q   <= '0;
            sign_q  <= 1'b0;
            stop_q  <= 1'b0;
            act_q   <= '0;
            sout_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tgt_q   <= tgt_d;
            sign_q  <= sign_d;
            stop_q  <= stop_d;
            act_q   <= act_d;
            sout_q  <= sout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            fault_q <= fault_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tgt_d   = tgt_q;
        sign_d  = sign_q;
        stop_d  = stop_q;
        act_d   = act_q;
        if (Short) begin
            state_d = FAULT;
            cnt_d   = '0;
            stop_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && desired_valid) begin
                        state_d = CONDUCT;
                        act_d   = DesiredLoad;
                    end
                end
                CONDUCT: begin
                    if (!start) begin
                        state_d = IDLE;
                    end else if (desired_valid && (DesiredLoad != act_q)) begin
                        state_d = STEP1;
                        tgt_d   = DesiredLoad;
                        sign_d  = CurrentSign;
                        stop_d  = 1'b0;
                        cnt_d   = CNT_RELOAD;
                    end
                end
                STEP1, STEP2: begin
                    stop_d = stop_q | ~start;
                    if (cnt_q == '0) begin
                        state_d = (state_q == STEP1) ? STEP2 : STEP3;
                        cnt_d   = CNT_RELOAD;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                STEP3: begin
                    stop_d = stop_q | ~start;
                    if (cnt_q == '0) begin
                        // a stop request seen anywhere in the sequence lands in IDLE, not the new load
                        if (stop_q || !start) begin
                            state_d = IDLE;
                        end else begin
                            state_d = CONDUCT;
                            act_d   = tgt_q;
                        end
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                FAULT: begin
                    if (!start) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Outputs are precomputed from the next state so they appear registered in the same cycle as the state.
    always_comb begin
        sout_d  = '0;
        busy_d  = (state_d == STEP1) || (state_d == STEP2) || (state_d == STEP3);
        done_d  = (state_d == CONDUCT) && (state_q != CONDUCT);
        fault_d = (state_d == FAULT);
        for (int k = 0; k < N_LOADS; k++) begin
            if (state_d == CONDUCT && act_d == SEL_W'(k)) begin
                sout_d[2*k]   = 1'b1;
                sout_d[2*k+1] = 1'b1;
            end
            if (((state_d == STEP1 || state_d == STEP2) && act_d == SEL_W'(k)) ||
                ((state_d == STEP2 || state_d == STEP3) && tgt_d == SEL_W'(k))) begin
                if (sign_d) sout_d[2*k]   = 1'b1;
                else        sout_d[2*k+1] = 1'b1;
            end
        end
    end

    assign Sout        = sout_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign fault       = fault_q;
    assign active_load = act_q;

endmodule

// File: tb/tb_commutation_fsm.sv
// Bench for commutation_fsm: directed vector table, hand-written corner sequences, and random
// stimulus checked against a phase-arithmetic reference model.
module tb_commutation_fsm;

    localparam int N  = 3;
    localparam int SW = 2;
    localparam int S  = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [SW-1:0] DesiredLoad;
    logic          CurrentSign;
    logic          Short;
    logic [2*N-1:0] Sout;
    logic          busy, done, fault;
    logic [SW-1:0] active_load;

    int n_checks = 0;
    int n_fail   = 0;

    commutation_fsm #(.N_LOADS(N), .SEL_W(SW), .STEP_CYCLES(S)) dut (
        .clk(clk), .rst(rst), .start(start), .DesiredLoad(DesiredLoad),
        .CurrentSign(CurrentSign), .Short(Short), .Sout(Sout), .busy(busy),
        .done(done), .fault(fault), .active_load(active_load)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       st;
        logic [1:0] dl;
        logic       cs;
        logic       sh;
        logic [5:0] sout;
        logic       busy;
        logic       done;
        logic       fault;
        logic [1:0] al;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input int n, input logic st, input logic [1:0] dl, input logic cs, input logic sh,
                       input logic [5:0] so, input logic b, input logic d, input logic f, input logic [1:0] al);
        vec_t v;
        for (int i = 0; i < n; i++) begin
            v.st = st; v.dl = dl; v.cs = cs; v.sh = sh;
            v.sout = so; v.busy = b; v.done = d; v.fault = f; v.al = al;
            tbl.push_back(v);
        end
    endtask

    function automatic logic [10:0] dut_out();
        return {Sout, busy, done, fault, active_load};
    endfunction

    task automatic check(input string name, input logic [10:0] act, input logic [10:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got Sout/busy/done/fault/al=%b required %b", name, act, exp);
        end
    endtask

    // Reference model: modes and elapsed-cycle arithmetic, phase = elapsed / S.
    localparam int M_IDLE = 0, M_COND = 1, M_COMM = 2, M_FAULT = 3;
    int m_mode, m_a, m_b, m_el;
    bit m_s, m_stop, m_done;

    function automatic void model_reset();
        m_mode = M_IDLE; m_a = 0; m_b = 0; m_el = 0; m_s = 0; m_stop = 0; m_done = 0;
    endfunction

    function automatic void model_step(input bit st, input int dl, input bit cs, input bit sh);
        m_done = 0;
        if (sh) begin
            m_mode = M_FAULT;
            return;
        end
        case (m_mode)
            M_IDLE: if (st && dl < N) begin m_mode = M_COND; m_a = dl; m_done = 1; end
            M_COND: begin
                if (!st) m_mode = M_IDLE;
                else if (dl < N && dl != m_a) begin
                    m_mode = M_COMM; m_b = dl; m_s = cs; m_el = 0; m_stop = 0;
                end
            end
            M_COMM: begin
                m_stop = m_stop | !st;
                m_el++;
                if (m_el == 3*S) begin
                    if (m_stop) m_mode = M_IDLE;
                    else begin m_mode = M_COND; m_a = m_b; m_done = 1; end
                end
            end
            default: if (!st) m_mode = M_IDLE;
        endcase
    endfunction

    function automatic logic [10:0] model_out();
        logic [5:0] so;
        int dev, ph;
        so = '0;
        dev = m_s ? 0 : 1;
        if (m_mode == M_COND) begin
            so[2*m_a] = 1'b1; so[2*m_a+1] = 1'b1;
        end else if (m_mode == M_COMM) begin
            ph = m_el / S;
            if (ph < 2) so[2*m_a+dev] = 1'b1;
            if (ph > 0) so[2*m_b+dev] = 1'b1;
        end
        return {so, m_mode == M_COMM, m_done, m_mode == M_FAULT, m_a[1:0]};
    endfunction

    task automatic model_cycle(input string name, input bit st, input logic [1:0] dl, input bit cs, input bit sh);
        start = st; DesiredLoad = dl; CurrentSign = cs; Short = sh;
        model_step(st, int'(dl), cs, sh);
        @(posedge clk);
        #1;
        check(name, dut_out(), model_out());
    endtask

    function automatic bit gates_safe(input logic [5:0] so);
        int ones, full;
        ones = 0; full = 0;
        for (int k = 0; k < 2*N; k++) ones += int'(so[k]);
        for (int k = 0; k < N; k++) full += int'(so[2*k] & so[2*k+1]);
        return (ones <= 2) && (full <= 1) && !(full == 1 && ones == 2 && so[1:0] != 2'b11 &&
               so[3:2] != 2'b11 && so[5:4] != 2'b11);
    endfunction

    initial begin
        rst = 1'b0; start = 1'b0; DesiredLoad = '0; CurrentSign = 1'b0; Short = 1'b0;

        // Directed table following the commutation test plan.
        add(10, 0, 0, 0, 0, 6'b000000, 0, 0, 0, 0);
        add(1,  1, 0, 1, 0, 6'b000011, 0, 1, 0, 0);
        add(1,  1, 0, 1, 0, 6'b000011, 0, 0, 0, 0);
        add(4,  1, 2, 1, 0, 6'b000001, 1, 0, 0, 0);
        add(4,  1, 2, 1, 0, 6'b010001, 1, 0, 0, 0);
        add(4,  1, 2, 1, 0, 6'b010000, 1, 0, 0, 0);
        add(1,  1, 2, 1, 0, 6'b110000, 0, 1, 0, 2);
        add(1,  1, 2, 1, 0, 6'b110000, 0, 0, 0, 2);
        for (int i = 0; i < 4; i++) add(1, 1, 1, i[0], 0, 6'b100000, 1, 0, 0, 2);
        for (int i = 0; i < 4; i++) add(1, 1, 1, ~i[0], 0, 6'b101000, 1, 0, 0, 2);
        for (int i = 0; i < 4; i++) add(1, 1, 1, i[0], 0, 6'b001000, 1, 0, 0, 2);
        add(1,  1, 1, 1, 0, 6'b001100, 0, 1, 0, 1);
        add(4,  1, 0, 1, 0, 6'b000100, 1, 0, 0, 1);
        add(2,  1, 0, 1, 0, 6'b000101, 1, 0, 0, 1);
        add(1,  1, 0, 1, 1, 6'b000000, 0, 0, 1, 1);
        add(2,  1, 1, 0, 0, 6'b000000, 0, 0, 1, 1);
        add(1,  0, 1, 0, 0, 6'b000000, 0, 0, 0, 1);
        add(1,  1, 1, 0, 0, 6'b001100, 0, 1, 0, 1);
        add(2,  1, 3, 0, 0, 6'b001100, 0, 0, 0, 1);
        add(1,  1, 0, 1, 0, 6'b000100, 1, 0, 0, 1);
        add(3,  0, 0, 1, 0, 6'b000100, 1, 0, 0, 1);
        add(4,  0, 0, 1, 0, 6'b000101, 1, 0, 0, 1);
        add(4,  0, 0, 1, 0, 6'b000001, 1, 0, 0, 1);
        add(2,  0, 0, 1, 0, 6'b000000, 0, 0, 0, 1);

        repeat (2) @(posedge clk);
        #1;
        check("reset_values", dut_out(), 11'b0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < tbl.size(); i++) begin
            start = tbl[i].st; DesiredLoad = tbl[i].dl; CurrentSign = tbl[i].cs; Short = tbl[i].sh;
            @(posedge clk);
            #1;
            $display("vec %0d: st=%b dl=%0d cs=%b sh=%b -> Sout=%b busy=%b done=%b fault=%b al=%0d",
                     i, tbl[i].st, tbl[i].dl, tbl[i].cs, tbl[i].sh, Sout, busy, done, fault, active_load);
            check($sformatf("vec%0d", i), dut_out(),
                  {tbl[i].sout, tbl[i].busy, tbl[i].done, tbl[i].fault, tbl[i].al});
        end

        // Asynchronous reset in the middle of STEP2.
        rst = 1'b0; start = 1'b0; Short = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        model_cycle("seq_energise", 1, 2'd0, 1'b0, 1'b0);
        model_cycle("seq_request", 1, 2'd1, 1'b0, 1'b0);
        for (int i = 0; i < S + 1; i++) model_cycle("seq_step", 1, 2'd1, 1'b0, 1'b0);
        check("pre_reset_step2", {Sout, busy, 4'b0}, {6'b001010, 1'b1, 4'b0});
        #2 rst = 1'b0;
        #1;
        $display("async reset mid-STEP2 -> Sout=%b busy=%b al=%0d", Sout, busy, active_load);
        check("async_reset", dut_out(), 11'b0);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        model_reset();

        // Randomized run against the reference model, with a gate-safety check each cycle.
        for (int i = 0; i < 600; i++) begin
            logic       st, cs, sh;
            logic [1:0] dl;
            st = ($urandom_range(0, 9) != 0);
            dl = 2'($urandom_range(0, 3));
            cs = 1'($urandom);
            sh = ($urandom_range(0, 59) == 0);
            model_cycle($sformatf("rand%0d", i), st, dl, cs, sh);
            $display("rnd %0d: st=%b dl=%0d cs=%b sh=%b -> Sout=%b busy=%b done=%b fault=%b al=%0d",
                     i, st, dl, cs, sh, Sout, busy, done, fault, active_load);
            n_checks++;
            if (!gates_safe(Sout)) begin
                n_fail++;
                $display("FAIL gate_safety%0d: got Sout=%b required at most one pair or two single devices", i, Sout);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
